uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one UART transmitter between NUM_REQ requesters. Each requester offers a byte plus a parity select over a valid/ready handshake. The block grants one requester, launches the transmitter via tx_enable, even_odd and tx_data_in, and tracks the transmitter's busy flag until the frame completes. It sits between the host-side byte sources and the transmitter instance.

---
 rtl/uart_tx_sched_if.sv | 12 +
 rtl/uart_tx_sched.sv | 122 ++++++++++++
 tb/tb_uart_tx_sched.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// Requester-side handshake bundle: per-requester byte, parity select and valid/ready.
interface uart_tx_sched_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_parity;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (output req_valid, output req_data, output req_parity, input req_ready);
  modport slave  (input req_valid, input req_data, input req_parity, output req_ready);
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte sources.
// Launches the transmitter, watches its busy flag and inserts an idle gap between frames.
module uart_tx_sched #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned BUSY_TIMEOUT = 16,
  parameter int unsigned GAP_CYCLES   = 2,
  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic              sys_clk,
  input  logic              rst,
  uart_tx_sched_if.slave    req,
  output logic              tx_enable,
  output logic              even_odd,
  output logic [7:0]        tx_data_in,
  input  logic              tx_busy,
  output logic [IDW-1:0]    grant_id,
  output logic              active,
  output logic              err_timeout
);
  localparam int unsigned TOW = $clog2(BUSY_TIMEOUT + 1);
  localparam int unsigned GPW = $clog2(GAP_CYCLES + 2);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   idx;
  logic             any_valid;
  logic             accept;
  logic [TOW-1:0]   to_cnt;
  logic [GPW-1:0]   gap_cnt;

  // First valid requester at or above the rr pointer, wrapping modulo NUM_REQ.
  always_comb begin
    win       = '0;
    idx       = '0;
    any_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((32'(rr_ptr) + k) % NUM_REQ);
      if (!any_valid && req.req_valid[idx]) begin
        win       = idx;
        any_valid = 1'b1;
      end
    end
  end

  assign accept = (state == IDLE) && !tx_busy && any_valid;

  always_comb begin
    req.req_ready = '0;
    if (accept) req.req_ready[win] = 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      tx_enable   <= 1'b0;
      even_odd    <= 1'b0;
      tx_data_in  <= '0;
      grant_id    <= '0;
      active      <= 1'b0;
      err_timeout <= 1'b0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
    end else begin
      err_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            tx_data_in <= req.req_data[{win, 3'b000} +: 8];
            even_odd   <= req.req_parity[win];
            grant_id   <= win;
            rr_ptr     <= (32'(win) + 1 == NUM_REQ) ? '0 : win + 1'b1;
            active     <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_enable <= 1'b1;
          to_cnt    <= '0;
          state     <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // Busy is checked first so it wins on the expiry edge.
          if (tx_busy) begin
            tx_enable <= 1'b0;
            state     <= WAIT_DONE;
          end else if (32'(to_cnt) + 1 >= BUSY_TIMEOUT) begin
            tx_enable   <= 1'b0;
            err_timeout <= 1'b1;
            active      <= 1'b0;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (GAP_CYCLES == 0) begin
              active <= 1'b0;
              state  <= IDLE;
            end else begin
              gap_cnt <= '0;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (32'(gap_cnt) + 1 >= GAP_CYCLES) begin
            active <= 1'b0;
            state  <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: behavioural transmitter, round-robin reference and frame scoreboard.
module tb_uart_tx_sched;
  localparam int unsigned N   = 4;
  localparam int unsigned TO  = 16;
  localparam int unsigned GAP = 2;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_enable, even_odd, tx_busy, active, err_timeout;
  logic [7:0] tx_data_in;
  logic [1:0] grant_id;

  logic        tx_model_on = 1'b1;
  logic        busy_force = 1'b0;
  logic        busy_model = 1'b0;
  int unsigned txm_left = 0;
  logic [8:0]  got_q[$];
  logic [8:0]  exp_q[$];
  int unsigned acc_q[$];
  logic [8:0]  pend [N][16];
  int unsigned head [N];
  int unsigned tail [N];
  int unsigned n_cmp = 0, n_bad = 0, ptr_m = 0;

  uart_tx_sched_if #(.NUM_REQ(N)) req ();

  uart_tx_sched #(.NUM_REQ(N), .BUSY_TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
    .sys_clk(sys_clk), .rst(rst), .req(req),
    .tx_enable(tx_enable), .even_odd(even_odd), .tx_data_in(tx_data_in),
    .tx_busy(tx_busy), .grant_id(grant_id), .active(active), .err_timeout(err_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  assign tx_busy = tx_model_on ? busy_model : busy_force;

  // Transmitter: picks up a launch, records the frame, stays busy a random 3..7 cycles.
  always @(posedge sys_clk) begin
    if (!tx_model_on) busy_model <= 1'b0;
    else if (busy_model) begin
      if (txm_left == 0) busy_model <= 1'b0;
      else txm_left <= txm_left - 1;
    end else if (tx_enable) begin
      busy_model <= 1'b1;
      txm_left   <= $urandom_range(6, 2);
      got_q.push_back({even_odd, tx_data_in});
    end
  end

  function automatic int unsigned winner(input logic [N-1:0] v, input int unsigned p);
    for (int unsigned k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
    got_q.delete(); exp_q.delete(); acc_q.delete();
  endtask

  task automatic enqueue(input int unsigned i, input logic [7:0] d, input logic p);
    pend[i][tail[i]] = {p, d};
    tail[i]++;
  endtask

  // Drives queued bytes, predicts every ready pulse and scores frames against accepts.
  task automatic run_traffic(input string tag, input int unsigned max_cycles, input bit rand_mode);
    logic [N-1:0] rdy, exp_rdy;
    logic [8:0]   lat_v = '0;
    int unsigned  lat_w = 0, w;
    bit           lat_pend = 0, done = 0, drained;
    int           drop_id = -1;
    for (int unsigned c = 0; c < max_cycles && !done; c++) begin
      @(negedge sys_clk);
      if (drop_id >= 0) begin
        req.req_valid[drop_id] = 1'b0;
        head[drop_id]++;
        drop_id = -1;
      end
      for (int i = 0; i < N; i++) begin
        if (req.req_valid[i] && rand_mode && $urandom_range(15, 0) == 0)
          req.req_valid[i] = 1'b0;
        else if (!req.req_valid[i] && head[i] < tail[i] && (!rand_mode || $urandom_range(2, 0) != 0)) begin
          req.req_valid[i]         = 1'b1;
          req.req_data[8*i +: 8]   = pend[i][head[i]][7:0];
          req.req_parity[i]        = pend[i][head[i]][8];
        end
      end
      #1;
      if (lat_pend) begin
        n_cmp++;
        if ({even_odd, tx_data_in, grant_id, active} !== {lat_v, 2'(lat_w), 1'b1}) begin
          n_bad++;
          $display("FAIL %s_latch: got par=%b data=%h id=%0d act=%b want par=%b data=%h id=%0d act=1",
                   tag, even_odd, tx_data_in, grant_id, active, lat_v[8], lat_v[7:0], lat_w);
        end
        lat_pend = 0;
      end
      rdy     = req.req_ready;
      exp_rdy = '0;
      w       = winner(req.req_valid, ptr_m);
      if (!active && !tx_busy && req.req_valid != '0) exp_rdy[w] = 1'b1;
      n_cmp++;
      if (rdy !== exp_rdy) begin
        n_bad++;
        $display("FAIL %s_ready: cycle %0d got %b want %b", tag, c, rdy, exp_rdy);
      end else if (rdy != '0) begin
        lat_v    = {req.req_parity[w], req.req_data[8*w +: 8]};
        lat_w    = w;
        lat_pend = 1;
        exp_q.push_back(lat_v);
        acc_q.push_back(w);
        ptr_m    = (w + 1) % N;
        drop_id  = int'(w);
      end
      while (got_q.size() > 0) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL %s_frame: got %h want none", tag, got_q[0]);
        end else begin
          if (got_q[0] !== exp_q[0]) begin
            n_bad++;
            $display("FAIL %s_frame: got %h want %h", tag, got_q[0], exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        void'(got_q.pop_front());
      end
      drained = 1;
      for (int i = 0; i < N; i++) if (head[i] < tail[i]) drained = 0;
      done = drained && drop_id < 0 && !lat_pend && !active && exp_q.size() == 0 && req.req_valid == '0;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s_drain: got pending=%0d want 0 within %0d cycles", tag, exp_q.size(), max_cycles);
    end
  endtask

  task automatic test_reset();
    req.req_valid = '0; req.req_data = '0; req.req_parity = '0;
    rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk); #1;
    n_cmp++;
    if ({tx_enable, even_odd, tx_data_in, grant_id, active, err_timeout, req.req_ready} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got en=%b par=%b data=%h id=%0d act=%b err=%b rdy=%b want all 0",
               tx_enable, even_odd, tx_data_in, grant_id, active, err_timeout, req.req_ready);
    end
    rst = 1'b0; ptr_m = 0;
  endtask

  task automatic test_single();
    int unsigned rdy_extra = 0, en_cnt = 0, gap_seen = 0;
    bit busy_seen = 0;
    clear_all();
    @(negedge sys_clk);
    req.req_valid = 4'b0001; req.req_data[7:0] = 8'haa; req.req_parity = '0;
    #1;
    n_cmp++;
    if (req.req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready: got %b want 0001", req.req_ready); end
    @(negedge sys_clk); req.req_valid = '0; #1;
    n_cmp++;
    if ({tx_data_in, even_odd, grant_id, active} !== {8'haa, 1'b0, 2'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL single_latch: got data=%h par=%b id=%0d act=%b want aa 0 0 1", tx_data_in, even_odd, grant_id, active);
    end
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin @(negedge sys_clk); #1; end
      if (req.req_ready != '0) rdy_extra++;
      if (tx_enable) en_cnt++;
      if (tx_busy) busy_seen = 1;
      else if (busy_seen && active) gap_seen++;
    end
    n_cmp++;
    if (rdy_extra != 0) begin n_bad++; $display("FAIL single_ready_once: got %0d extra want 0", rdy_extra); end
    // Transmitter reacts one edge after seeing enable; scheduler drops enable on the next.
    n_cmp++;
    if (en_cnt != 2) begin n_bad++; $display("FAIL single_enable_len: got %0d want 2", en_cnt); end
    // One cycle to notice busy low, then GAP idle cycles.
    n_cmp++;
    if (gap_seen != GAP + 1) begin n_bad++; $display("FAIL single_gap: got %0d want %0d", gap_seen, GAP + 1); end
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== {1'b0, 8'haa}) begin
      n_bad++;
      $display("FAIL single_frame: got n=%0d want one frame 0aa", got_q.size());
    end
    got_q.delete();
    ptr_m = 1;
  endtask

  task automatic test_back_to_back();
    test_reset();
    clear_all();
    enqueue(0, 8'h11, 1'b0); enqueue(1, 8'h22, 1'b1);
    enqueue(2, 8'h33, 1'b0); enqueue(3, 8'h44, 1'b1);
    run_traffic("b2b", 200, 1'b0);
    n_cmp++;
    if (acc_q.size() != 4 || acc_q[0] != 0 || acc_q[1] != 1 || acc_q[2] != 2 || acc_q[3] != 3) begin
      n_bad++;
      $display("FAIL b2b_order: got %p want 0 1 2 3", acc_q);
    end
  endtask

  task automatic test_rotation();
    clear_all();
    enqueue(2, 8'h5c, 1'b1);
    run_traffic("rot_a", 100, 1'b0);
    clear_all();
    enqueue(0, 8'h01, 1'b0); enqueue(2, 8'h02, 1'b1);
    run_traffic("rot_b", 200, 1'b0);
    n_cmp++;
    if (acc_q.size() != 2 || acc_q[0] != 0 || acc_q[1] != 2) begin
      n_bad++;
      $display("FAIL rotation_order: got %p want 0 2", acc_q);
    end
  endtask

  task automatic test_timeout();
    int unsigned en_cnt = 0, err_cnt = 0;
    bit seen_err = 0;
    clear_all();
    tx_model_on = 1'b0; busy_force = 1'b0;
    @(negedge sys_clk);
    req.req_valid = 4'b0010; req.req_data[15:8] = 8'h5a; req.req_parity = 4'b0010;
    #1;
    for (int c = 0; c < 40 && !seen_err; c++) begin
      if (c > 0) begin @(negedge sys_clk); #1; end
      if (err_timeout) begin
        seen_err = 1;
        n_cmp++;
        if (en_cnt != TO) begin n_bad++; $display("FAIL timeout_enable_len: got %0d want %0d", en_cnt, TO); end
        n_cmp++;
        if ({tx_enable, active, req.req_ready} !== {1'b0, 1'b0, 4'b0010}) begin
          n_bad++;
          $display("FAIL timeout_idle: got en=%b act=%b rdy=%b want 0 0 0010", tx_enable, active, req.req_ready);
        end
      end
      if (tx_enable) en_cnt++;
    end
    n_cmp++;
    if (!seen_err) begin n_bad++; $display("FAIL timeout_pulse: got none want 1 within 40 cycles"); end
    @(negedge sys_clk);
    req.req_valid = '0; tx_model_on = 1'b1;
    #1;
    for (int c = 0; c < 60 && active; c++) begin
      if (err_timeout) err_cnt++;
      @(negedge sys_clk); #1;
    end
    n_cmp++;
    if (err_cnt != 0 || active !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_reaccept: got err=%0d act=%b want 0 0", err_cnt, active);
    end
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== {1'b1, 8'h5a}) begin
      n_bad++;
      $display("FAIL timeout_frame: got n=%0d want one frame 15a", got_q.size());
    end
    got_q.delete();
    ptr_m = 2;
  endtask

  task automatic test_busy_at_expiry();
    int unsigned en_cnt = 0, err_cnt = 0;
    tx_model_on = 1'b0; busy_force = 1'b0;
    @(negedge sys_clk);
    req.req_valid = 4'b0001; req.req_data[7:0] = 8'h77; req.req_parity = 4'b0001;
    #1;
    n_cmp++;
    if (req.req_ready !== 4'b0001) begin n_bad++; $display("FAIL expiry_ready: got %b want 0001", req.req_ready); end
    @(negedge sys_clk); req.req_valid = '0; #1;
    for (int c = 0; c < 40 && en_cnt < TO; c++) begin
      @(negedge sys_clk); #1;
      if (tx_enable) en_cnt++;
    end
    // Busy lands exactly on the edge where the wait counter expires.
    busy_force = 1'b1;
    @(negedge sys_clk); #1;
    n_cmp++;
    if ({err_timeout, tx_enable, active} !== 3'b001) begin
      n_bad++;
      $display("FAIL expiry_busy_wins: got err=%b en=%b act=%b want 0 0 1", err_timeout, tx_enable, active);
    end
    repeat (3) @(negedge sys_clk);
    busy_force = 1'b0;
    #1;
    for (int c = 0; c < 20 && active; c++) begin
      if (err_timeout) err_cnt++;
      @(negedge sys_clk); #1;
    end
    n_cmp++;
    if (err_cnt != 0 || active !== 1'b0) begin
      n_bad++;
      $display("FAIL expiry_finish: got err=%0d act=%b want 0 0", err_cnt, active);
    end
    tx_model_on = 1'b1;
    ptr_m = 1;
  endtask

  task automatic test_blocked();
    int unsigned bad_rdy = 0;
    tx_model_on = 1'b0; busy_force = 1'b1;
    @(negedge sys_clk);
    req.req_valid = 4'b1000; req.req_data[31:24] = 8'h3c; req.req_parity = '0;
    #1;
    for (int c = 0; c < 5; c++) begin
      if (req.req_ready != '0) bad_rdy++;
      @(negedge sys_clk); #1;
    end
    n_cmp++;
    if (bad_rdy != 0) begin n_bad++; $display("FAIL blocked_ready: got %0d ready cycles want 0", bad_rdy); end
    busy_force = 1'b0;
    #1;
    n_cmp++;
    if (req.req_ready !== 4'b1000) begin n_bad++; $display("FAIL blocked_release: got %b want 1000", req.req_ready); end
    @(negedge sys_clk);
    req.req_valid = '0; tx_model_on = 1'b1;
    #1;
    for (int c = 0; c < 60 && active; c++) begin @(negedge sys_clk); #1; end
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== {1'b0, 8'h3c} || active !== 1'b0) begin
      n_bad++;
      $display("FAIL blocked_frame: got n=%0d act=%b want one frame 03c act 0", got_q.size(), active);
    end
    got_q.delete();
    ptr_m = 0;
  endtask

  task automatic test_reset_mid();
    int unsigned err_cnt = 0;
    bit in_done = 0;
    @(negedge sys_clk);
    req.req_valid = 4'b0100; req.req_data[23:16] = 8'he7; req.req_parity = '0;
    #1;
    @(negedge sys_clk); req.req_valid = '0; #1;
    for (int c = 0; c < 20 && !in_done; c++) begin
      @(negedge sys_clk); #1;
      in_done = tx_busy && !tx_enable && active;
    end
    n_cmp++;
    if (!in_done) begin n_bad++; $display("FAIL midreset_reach: got none want transmit in progress"); end
    rst = 1'b1; tx_model_on = 1'b0;
    @(negedge sys_clk); #1;
    n_cmp++;
    if ({tx_enable, even_odd, tx_data_in, grant_id, active, err_timeout, req.req_ready} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got en=%b par=%b data=%h id=%0d act=%b err=%b rdy=%b want all 0",
               tx_enable, even_odd, tx_data_in, grant_id, active, err_timeout, req.req_ready);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge sys_clk); #1;
      if (err_timeout || req.req_ready != '0) err_cnt++;
    end
    n_cmp++;
    if (err_cnt != 0) begin n_bad++; $display("FAIL midreset_quiet: got %0d pulses want 0", err_cnt); end
    rst = 1'b0; tx_model_on = 1'b1; ptr_m = 0;
    clear_all();
    enqueue(1, 8'hb1, 1'b1); enqueue(3, 8'hb3, 1'b0);
    run_traffic("midreset", 200, 1'b0);
    n_cmp++;
    if (acc_q.size() != 2 || acc_q[0] != 1 || acc_q[1] != 3) begin
      n_bad++;
      $display("FAIL midreset_order: got %p want 1 3", acc_q);
    end
  endtask

  task automatic test_random();
    int unsigned i;
    clear_all();
    for (int k = 0; k < 40; k++) begin
      i = $urandom_range(N - 1, 0);
      if (tail[i] < 16) enqueue(i, 8'($urandom), 1'($urandom));
    end
    run_traffic("random", 4000, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_rotation();
    test_timeout();
    test_busy_at_expiry();
    test_blocked();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish want finish before 1ms");
    $fatal(1, "watchdog expired");
  end
endmodule
